mux_rr_arbiter: RTL
===================

Name: mux_rr_arbiter

Overview:
- Shares one W-bit output channel, a registered N:1 mux, between N requesters using round-robin arbitration.
- Each requester uses a valid/ready handshake. The output is a single-entry registered buffer with its own valid/ready handshake.
- Used wherever several producers must time-share one downstream consumer through the mux datapath.

Parameters:
- N, 4, number of requesters (N >= 2)
- W, 8, data width per requester

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  N  bit k = requester k has data
- req_data  input  N*W  requester k data in bits [k*W +: W]
- req_ready  output  N  one-hot or zero; bit k = requester k's transfer is accepted this cycle
- out_valid  output  1  output buffer holds a word
- out_data  output  W  buffered word
- out_id  output  $clog2(N)  index of the requester that supplied out_data
- out_ready  input  1  downstream accepts the word

Behaviour:
- Reset (async, active-high):
  - out_valid=0, out_data=0, out_id=0.
  - Priority pointer ptr=0, so requester 0 has highest priority first.
  - req_ready is 0 for the whole time rst is high.
- Buffer state is implied by out_valid:
  - EMPTY (out_valid=0)
  - FULL (out_valid=1)
- can_accept = !out_valid | out_ready. This is combinational.
- Grant selection (combinational):
  - Search k = ptr, ptr+1, ..., ptr+N-1, modulo N.
  - The first k with req_valid[k]=1 is the winner.
  - When can_accept=1 and a winner exists, req_ready = one-hot(winner). Otherwise req_ready = 0.
  - req_ready may depend combinationally on out_ready. This pass-through is intended and permits full throughput.
- Transfer: requester k transfers when req_valid[k] & req_ready[k]. On that rising edge:
  - out_data <= req_data[k]
  - out_id <= k
  - out_valid <= 1
  - ptr <= (k+1) mod N. Wrap: when k = N-1, ptr becomes 0.
- Drain without refill: when out_valid & out_ready and no winner exists, out_valid <= 0. out_data and out_id hold their last values.
- Simultaneous drain and refill in the same cycle: the buffer stays FULL with the new word. One word per cycle is sustained.
- Stall: out_valid=1 and out_ready=0 gives req_ready=0. out_data, out_id and ptr are stable. The requester must hold req_valid and req_data.
- No grant: ptr changes only on a transfer. Idle cycles do not move priority.
- Fairness: every continuously valid requester is granted within N transfers.
- Latency: a granted word appears on out_data one cycle after its handshake cycle.
- Rule for requesters: req_valid must not drop before acceptance. The arbiter does not check this rule. A dropped request simply loses arbitration.
- Reset mid-operation:
  - The buffered word is discarded and out_valid falls immediately (asynchronously).
  - ptr returns to 0.
  - No grant is issued while rst is high.
- Output data is never combinationally forwarded from input to output. out_* are pure registers.

Test Plan:
- Reset then idle: assert rst mid-run with out_valid=1 → out_valid=0, out_data=0, out_id=0 immediately; req_ready=0 while rst is high; after release, a sole req_valid=4'b0100 with data 8'h33 → req_ready=4'b0100, and the next cycle out_valid=1, out_data=8'h33, out_id=2.
- All requesters valid continuously, out_ready=1, data k→8'hA0+k: out_id sequence 0,1,2,3,0,1 on consecutive cycles; out_data A0,A1,A2,A3,A0,…; one word per cycle.
- Pointer wrap: grant requester 3 alone, then req_valid=4'b1001 → requester 0 is granted next (ptr wrapped to 0), then requester 3.
- Backpressure: buffer FULL and out_ready=0 for 5 cycles with req_valid=4'b1111 → req_ready=0 throughout; out_data/out_id unchanged; on out_ready=1, the next requester in order is granted in that same cycle.
- Drain to empty: single word, then out_ready=1 with no req_valid → out_valid falls next cycle; out_data holds its last value; ptr unchanged (a later all-valid request is granted starting after the last winner).
- Idle priority hold: grant requester 1, idle for 10 cycles, then req_valid=4'b1111 → requester 2 is granted first.

Source files
------------

// File: rtl/mux_rr_arbiter_if.sv
// Bundles the requester and downstream signals of the round-robin mux arbiter.
//   req_valid / req_data / req_ready : N requester channels (k-th lane at [k*W +: W])
//   out_valid / out_data / out_id    : registered output buffer with source index
//   out_ready                        : downstream accept
// slave  : arbiter side (takes requests, drives the output buffer)
// master : environment side (drives requests, consumes the output buffer)
interface mux_rr_arbiter_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_id;
  logic           out_ready;

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready,
    output out_valid,
    output out_data,
    output out_id,
    input  out_ready
  );

  modport master (
    output req_valid,
    output req_data,
    input  req_ready,
    input  out_valid,
    input  out_data,
    input  out_id,
    output out_ready
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter feeding a registered N:1 mux into a single-entry output
// buffer. Requesters handshake with valid/ready; the buffer drains through
// out_valid/out_ready and can be drained and refilled in the same cycle.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : mux_rr_arbiter_if.slave (req_valid, req_data, req_ready,
//         out_valid, out_data, out_id, out_ready)
module mux_rr_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input logic             clk,
  input logic             rst,
  mux_rr_arbiter_if.slave bus
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW = IW + 1;

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q,  out_data_d;
  logic [IW-1:0] out_id_q,    out_id_d;
  logic [IW-1:0] ptr_q,       ptr_d;

  logic          can_accept;
  logic          found;
  logic          transfer;
  logic [IW-1:0] win;
  logic [N-1:0]  grant;

  // First valid requester at or after ptr, wrapping modulo N
  always_comb begin
    logic [PW-1:0] pos;
    found = 1'b0;
    win   = '0;
    pos   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = PW'(ptr_q) + PW'(i);
      if (pos >= PW'(N)) pos = pos - PW'(N);
      if (!found && bus.req_valid[IW'(pos)]) begin
        found = 1'b1;
        win   = IW'(pos);
      end
    end
  end

  // Buffer can take a word when empty or being drained this cycle
  assign can_accept    = !out_valid_q || bus.out_ready;
  assign transfer      = can_accept && found && !rst;
  assign grant         = transfer ? (N'(1) << win) : '0;
  assign bus.req_ready = grant;

  // Next buffer/pointer state; refill takes precedence over drain
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    ptr_d       = ptr_q;
    if (transfer) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.req_data[win*W +: W];
      out_id_d    = win;
      ptr_d       = (win == IW'(N - 1)) ? '0 : win + IW'(1);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;

endmodule
